// File: rtl/sort_seq_ctrl_pkg.sv
// sort_pkg: shared state encoding and counter sizing for the sorting-array sequencer
package sort_pkg;
  typedef enum logic [1:0] {LOAD, DRAIN, FLUSH} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sort_seq_ctrl_if.sv
// sort_seq_ctrl_if: unsorted input stream and sorted output stream handshakes
interface sort_seq_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sort_seq_ctrl.sv
// sort_seq_ctrl: loads a set into the sorting-cell array, drains it in ascending order, then clears it
module sort_seq_ctrl
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CELLS  = 16,
  localparam int CNT_W     = cnt_w(NUM_CELLS)
) (
  input  logic                  clk,
  input  logic                  reset,
  sort_seq_ctrl_if.slave        s,
  output logic                  arr_enable,
  output logic                  arr_shift_up,
  output logic [DATA_WIDTH-1:0] arr_new_data,
  input  logic [DATA_WIDTH-1:0] arr_head_data,
  output logic                  arr_clear,
  output logic                  busy,
  output logic [CNT_W-1:0]      item_count
);
  state_t           state;
  logic [CNT_W-1:0] remain;
  logic             accept;
  logic             take;
  assign s.in_ready    = (state == LOAD) && (item_count < CNT_W'(NUM_CELLS));
  assign accept        = s.in_valid && s.in_ready;
  assign take          = (state == DRAIN) && s.out_ready;
  assign s.out_valid   = state == DRAIN;
  assign s.out_data    = arr_head_data;
  assign s.out_last    = (state == DRAIN) && (remain == CNT_W'(1));
  assign arr_enable    = accept || take;
  assign arr_shift_up  = take;
  assign arr_new_data  = s.in_data;
  assign arr_clear     = state == FLUSH;
  assign busy          = state != LOAD;
  // item_count keeps the loaded size through DRAIN; remain tracks what is still to be shifted out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      item_count <= '0;
      remain     <= '0;
    end else begin
      case (state)
        LOAD: if (accept) begin
          item_count <= item_count + 1'b1;
          if (s.in_last || item_count == CNT_W'(NUM_CELLS - 1)) begin
            state  <= DRAIN;
            remain <= item_count + 1'b1;
          end
        end
        DRAIN: if (take) begin
          remain <= remain - 1'b1;
          if (remain == CNT_W'(1)) state <= FLUSH;
        end
        default: begin
          state      <= LOAD;
          item_count <= '0;
          remain     <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sort_seq_ctrl.sv
// tb_sort_seq_ctrl: table-driven loopback bench with a behavioural sorting-cell array, NUM_CELLS=4
module tb_sort_seq_ctrl;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int CW = 3;

  typedef struct {
    logic          iv;
    logic          il;
    logic          ordy;
    logic [DW-1:0] d;
    logic          ir;
    logic          ov;
    logic          ol;
    logic          en;
    logic          sh;
    logic          clr;
    logic          by;
    logic [DW-1:0] od;
    logic [CW-1:0] cnt;
  } vec_t;

  logic          clk = 0;
  logic          reset = 1;
  logic          arr_enable, arr_shift_up, arr_clear, busy;
  logic [DW-1:0] arr_new_data, arr_head_data;
  logic [CW-1:0] item_count;
  logic [DW-1:0] cells [N];
  logic [DW-1:0] nxt [N];
  vec_t          v [$];
  int            ncmp = 0;
  int            nerr = 0;

  sort_seq_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  sort_seq_ctrl #(.DATA_WIDTH(DW), .NUM_CELLS(N)) dut (
    .clk(clk), .reset(reset), .s(bus.slave),
    .arr_enable(arr_enable), .arr_shift_up(arr_shift_up), .arr_new_data(arr_new_data),
    .arr_head_data(arr_head_data), .arr_clear(arr_clear), .busy(busy), .item_count(item_count)
  );

  always #5 clk = ~clk;

  assign arr_head_data = cells[0];

  // insertion on load keeps cells ascending; shift-up moves everything toward cell 0
  always @(posedge clk or posedge reset) begin
    if (reset || arr_clear) begin
      for (int i = 0; i < N; i++) cells[i] <= '1;
    end else if (arr_enable && arr_shift_up) begin
      for (int i = 0; i < N - 1; i++) cells[i] <= cells[i+1];
      cells[N-1] <= '1;
    end else if (arr_enable) begin
      int p;
      p = N;
      for (int i = N - 1; i >= 0; i--) if (arr_new_data <= cells[i]) p = i;
      for (int i = 0; i < N; i++) nxt[i] = cells[i];
      for (int i = N - 1; i > 0; i--) if (i > p) nxt[i] = cells[i-1];
      if (p < N) nxt[p] = arr_new_data;
      for (int i = 0; i < N; i++) cells[i] <= nxt[i];
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic ld(input logic [DW-1:0] d, input logic last, input logic [CW-1:0] cnt);
    v.push_back('{1'b1, last, 1'b0, d, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, cnt});
  endtask

  task automatic gap(input logic last, input logic [CW-1:0] cnt);
    v.push_back('{1'b0, last, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, cnt});
  endtask

  task automatic dr(input logic ordy, input logic [DW-1:0] od, input logic last);
    v.push_back('{1'b1, 1'b0, ordy, 8'h55, 1'b0, 1'b1, last, ordy, ordy, 1'b0, 1'b1, od, 3'd0});
  endtask

  task automatic fl();
    v.push_back('{1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 3'd0});
  endtask

  task automatic run(input string nm);
    foreach (v[k]) begin
      @(negedge clk);
      bus.in_valid  = v[k].iv;
      bus.in_last   = v[k].il;
      bus.in_data   = v[k].d;
      bus.out_ready = v[k].ordy;
      #2;
      chk({nm, ".flags"}, k,
          {25'd0, bus.in_ready, bus.out_valid, bus.out_last, arr_enable, arr_shift_up, arr_clear, busy},
          {25'd0, v[k].ir, v[k].ov, v[k].ol, v[k].en, v[k].sh, v[k].clr, v[k].by});
      if (v[k].ov) chk({nm, ".out_data"}, k, 32'(bus.out_data), 32'(v[k].od));
      if (!v[k].by) chk({nm, ".item_count"}, k, 32'(item_count), 32'(v[k].cnt));
      if (v[k].en && !v[k].sh) chk({nm, ".new_data"}, k, 32'(arr_new_data), 32'(v[k].d));
    end
    v.delete();
  endtask

  initial begin
    bus.in_valid = 0; bus.in_last = 0; bus.in_data = '0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("reset.state", 0, {28'd0, bus.in_ready, bus.out_valid, arr_enable, arr_clear},
        {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("reset.count", 0, 32'(item_count), 32'd0);
    @(negedge clk) reset = 0;

    ld(8'd5, 0, 0); ld(8'd2, 0, 1); ld(8'd9, 0, 2); ld(8'd1, 1, 3);
    dr(1, 8'd1, 0); dr(1, 8'd2, 0); dr(1, 8'd5, 0); dr(1, 8'd9, 1);
    fl(); gap(0, 0);
    run("basic");

    ld(8'd7, 0, 0); ld(8'd3, 0, 1); ld(8'd8, 0, 2); ld(8'd6, 0, 3);
    dr(1, 8'd3, 0); dr(1, 8'd6, 0); dr(1, 8'd7, 0); dr(1, 8'd8, 1);
    fl(); gap(0, 0);
    run("full");

    ld(8'd4, 0, 0); ld(8'hFF, 1, 1);
    dr(1, 8'd4, 0); dr(1, 8'hFF, 1);
    fl(); gap(0, 0);
    run("short");

    ld(8'd6, 0, 0); ld(8'd1, 0, 1); ld(8'd4, 1, 2);
    dr(1, 8'd1, 0); dr(0, 8'd4, 0); dr(0, 8'd4, 0); dr(1, 8'd4, 0); dr(1, 8'd6, 1);
    fl(); gap(0, 0);
    run("backpressure");

    ld(8'd2, 0, 0); gap(1, 1); gap(0, 1); gap(1, 1); ld(8'd1, 1, 1);
    dr(1, 8'd1, 0); dr(1, 8'd2, 1);
    fl(); gap(0, 0);
    run("gaps");

    ld(8'd8, 0, 0); ld(8'd3, 0, 1); ld(8'd5, 1, 2);
    dr(1, 8'd3, 0);
    run("pre_reset");
    @(negedge clk);
    bus.in_valid = 0; bus.out_ready = 1;
    #1 reset = 1;
    #1;
    chk("midreset.out_valid", 0, 32'(bus.out_valid), 32'd0);
    chk("midreset.in_ready", 0, 32'(bus.in_ready), 32'd1);
    chk("midreset.count", 0, 32'(item_count), 32'd0);
    chk("midreset.busy", 0, 32'(busy), 32'd0);
    @(negedge clk) reset = 0;

    ld(8'd9, 0, 0); ld(8'd7, 1, 1);
    dr(1, 8'd7, 0); dr(1, 8'd9, 1);
    fl(); gap(0, 0);
    run("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
